wlord_gen: RTL and testbench

- Instruction-driven wordline pattern generator; sits directly upstream of the per-channel level counter / divider stage and drives its wlord bus.
- Each channel outputs a programmable periodic waveform: HI cycles high, then LO cycles low, repeating.
- Downstream stage measures the high/low ratio, so duty = HI/(HI+LO) is fixed by the instruction stream.
- Instructions arrive over a valid/ready port. START/STOP control a global run window.

---
 rtl/wlord_gen_pkg.sv | 32 +++
 rtl/wlord_gen_if.sv | 26 ++
 rtl/wlord_gen_chan.sv | 61 ++++++
 rtl/wlord_gen.sv | 180 ++++++++++++++++++
 tb/tb_wlord_gen.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/wlord_gen_pkg.sv
// Shared definitions for the wordline pattern generator: opcodes, instruction field
// offsets and FSM states.
package wlord_gen_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_CFG   = 2'b01,
        OP_START = 2'b10,
        OP_STOP  = 2'b11
    } op_e;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    // ins_data layout, LSB first: lo[CW], hi[CW], ch[CHW], op[2]
    localparam int unsigned LO_LSB = 0;

    function automatic int unsigned hi_lsb(input int unsigned cw);
        return cw;
    endfunction

    function automatic int unsigned ch_lsb(input int unsigned cw);
        return 2 * cw;
    endfunction

    function automatic int unsigned op_lsb(input int unsigned cw, input int unsigned chw);
        return 2 * cw + chw;
    endfunction

endpackage

// File: rtl/wlord_gen_if.sv
// Instruction port and wordline output bundle of wlord_gen.
interface wlord_gen_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = 16,
    parameter int unsigned CHW   = 5
) ();

    logic                    ins_valid;
    logic                    ins_ready;
    logic [2+CHW+2*CW-1:0]   ins_data;
    logic [WIDTH-1:0]        wlord;
    logic                    busy;
    logic                    done;
    logic                    err;

    modport master (
        output ins_valid, ins_data,
        input  ins_ready, wlord, busy, done, err
    );

    modport slave (
        input  ins_valid, ins_data,
        output ins_ready, wlord, busy, done, err
    );

endinterface

// File: rtl/wlord_gen_chan.sv
// One wordline channel: HI cycles high then LO cycles low, restarted by start and
// forced low whenever the run window is closed.
module wlord_chan #(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          run,
    input  logic [CW-1:0] hi,
    input  logic [CW-1:0] lo,
    output logic          wlord
);

    logic          phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (start) begin
            phase_d = (hi != '0);
            cnt_d   = (hi != '0) ? hi : lo;
        end else if (!run) begin
            phase_d = 1'b0;
            cnt_d   = '0;
        end else if (cnt_q > CW'(1)) begin
            cnt_d = cnt_q - CW'(1);
        end else if (cnt_q == CW'(1)) begin
            // A zero-length opposite phase means stay put and reload the current length.
            if (phase_q) begin
                if (lo != '0) begin
                    phase_d = 1'b0;
                    cnt_d   = lo;
                end else begin
                    cnt_d = hi;
                end
            end else begin
                if (hi != '0) begin
                    phase_d = 1'b1;
                    cnt_d   = hi;
                end else begin
                    cnt_d = lo;
                end
            end
        end
    end

    assign wlord = phase_q;

endmodule

// File: rtl/wlord_gen.sv
// Instruction-driven wordline pattern generator top: decode, run FSM, channel config.
// Optional WLORD_GEN_CYCCNT_EN adds a saturating run_cycles counter output.
module wlord_gen
    import wlord_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = 16,
    parameter int unsigned CHW   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    wlord_gen_if.slave  bus
`ifdef WLORD_GEN_CYCCNT_EN
    ,
    output logic [31:0] run_cycles
`endif
);

    localparam int unsigned HiLsb = hi_lsb(CW);
    localparam int unsigned ChLsb = ch_lsb(CW);
    localparam int unsigned OpLsb = op_lsb(CW, CHW);

    op_e            op;
    logic [CHW-1:0] ch;
    logic [CW-1:0]  hi, lo;
    logic           ch_legal;

    assign op       = op_e'(bus.ins_data[OpLsb +: 2]);
    assign ch       = bus.ins_data[ChLsb +: CHW];
    assign hi       = bus.ins_data[HiLsb +: CW];
    assign lo       = bus.ins_data[LO_LSB +: CW];
    assign ch_legal = (32'(ch) < WIDTH);

    assign bus.ins_ready = rst_n;

    state_e        state_q, state_d;
    logic          start, cfg_we, err_d, done_d;
    logic          err_q, done_q;
    logic [CW-1:0] run_cnt_q, run_cnt_d;
    logic [CW-1:0] cfg_hi_q [WIDTH];
    logic [CW-1:0] cfg_hi_d [WIDTH];
    logic [CW-1:0] cfg_lo_q [WIDTH];
    logic [CW-1:0] cfg_lo_d [WIDTH];

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and instruction decode
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        cfg_we  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.ins_valid) begin
                    case (op)
                        OP_CFG: begin
                            if (ch_legal) cfg_we = 1'b1;
                            else          err_d  = 1'b1;
                        end
                        OP_START: begin
                            start   = 1'b1;
                            state_d = StRun;
                        end
                        default: ;
                    endcase
                end
            end
            StRun: begin
                if (bus.ins_valid && (op == OP_CFG || op == OP_START)) err_d = 1'b1;
                // Stop and expiry on the same edge collapse into one exit.
                if ((bus.ins_valid && op == OP_STOP) || run_cnt_q == CW'(1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        done_d   = (state_q == StRun) && (state_d == StIdle);
        bus.busy = (state_q == StRun);
    end

    always_comb begin
        run_cnt_d = run_cnt_q;
        if (start) begin
            run_cnt_d = hi;
        end else if (state_q == StRun && run_cnt_q != '0) begin
            run_cnt_d = run_cnt_q - CW'(1);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cfg_hi_d[i] = cfg_hi_q[i];
            cfg_lo_d[i] = cfg_lo_q[i];
            if (cfg_we && 32'(ch) == i) begin
                cfg_hi_d[i] = hi;
                cfg_lo_d[i] = lo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_cnt_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cfg_hi_q[i] <= '0;
                cfg_lo_q[i] <= '0;
            end
        end else begin
            run_cnt_q <= run_cnt_d;
            err_q     <= err_d;
            done_q    <= done_d;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cfg_hi_q[i] <= cfg_hi_d[i];
                cfg_lo_q[i] <= cfg_lo_d[i];
            end
        end
    end

    assign bus.err  = err_q;
    assign bus.done = done_q;

    logic             chan_run;
    logic [WIDTH-1:0] wlord_bits;

    assign chan_run = (state_d == StRun);

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        wlord_chan #(
            .CW (CW)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start),
            .run   (chan_run),
            .hi    (cfg_hi_q[g]),
            .lo    (cfg_lo_q[g]),
            .wlord (wlord_bits[g])
        );
    end

    assign bus.wlord = wlord_bits;

`ifdef WLORD_GEN_CYCCNT_EN
    logic [31:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (start) begin
            cyc_d = '0;
        end else if (state_q == StRun && cyc_q != '1) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign run_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_wlord_gen.sv
// Directed bench for wlord_gen. WIDTH is reduced to 20 so that a 5-bit channel index
// can actually address a nonexistent channel.
module tb_wlord_gen;

    localparam int unsigned W = 20;

    logic clk;
    logic rst_n;
    int   n_total = 0;
    int   n_bad   = 0;

    wlord_gen_if #(.WIDTH(W), .CW(16), .CHW(5)) bus ();

`ifdef WLORD_GEN_CYCCNT_EN
    logic [31:0] run_cycles;
`endif

    wlord_gen #(
        .WIDTH (W),
        .CW    (16),
        .CHW   (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus)
`ifdef WLORD_GEN_CYCCNT_EN
        ,
        .run_cycles (run_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input int ch, input int hi, input int lo);
        bus.ins_valid = 1'b1;
        bus.ins_data  = {op, 5'(ch), 16'(hi), 16'(lo)};
        tick();
        bus.ins_valid = 1'b0;
        bus.ins_data  = '0;
    endtask

    int pat [10] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0};

    initial begin
        rst_n         = 1'b0;
        bus.ins_valid = 1'b0;
        bus.ins_data  = '0;
        tick();
        tick();
        check_val("rst_wlord", 32'(bus.wlord), 32'h0);
        check_val("rst_busy", 32'(bus.busy), 32'h0);
        check_val("rst_done", 32'(bus.done), 32'h0);
        check_val("rst_err", 32'(bus.err), 32'h0);
        check_val("rst_ready", 32'(bus.ins_ready), 32'h0);
`ifdef WLORD_GEN_CYCCNT_EN
        check_val("rst_cyc", run_cycles, 32'h0);
`endif
        rst_n = 1'b1;
        #1;
        check_val("ready_out_of_rst", 32'(bus.ins_ready), 32'h1);

        // Single channel, bounded run of 10
        send(2'b01, 0, 3, 2);
        check_val("cfg0_err", 32'(bus.err), 32'h0);
        send(2'b10, 0, 10, 0);
        for (int k = 0; k < 10; k++) begin
            check_val("run10_wlord", 32'(bus.wlord), 32'(pat[k]));
            check_val("run10_busy", 32'(bus.busy), 32'h1);
            check_val("run10_done", 32'(bus.done), 32'h0);
            tick();
        end
        check_val("run10_end_wlord", 32'(bus.wlord), 32'h0);
        check_val("run10_end_busy", 32'(bus.busy), 32'h0);
        check_val("run10_end_done", 32'(bus.done), 32'h1);
        tick();
        check_val("run10_done_pulse", 32'(bus.done), 32'h0);

        // Degenerate channel configs alongside ch0 (still 3/2)
        send(2'b01, 1, 0, 4);
        send(2'b01, 2, 5, 0);
        send(2'b01, 3, 0, 0);
        send(2'b10, 0, 8, 0);
        for (int k = 0; k < 8; k++) begin
            check_val("degen_wlord", 32'(bus.wlord), 32'(pat[k]) | 32'h4);
            tick();
        end
        check_val("degen_end_wlord", 32'(bus.wlord), 32'h0);
        check_val("degen_end_done", 32'(bus.done), 32'h1);

        // Unbounded run, illegal CFG mid-run, then STOP
        send(2'b01, 0, 1, 1);
        send(2'b10, 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            check_val("unb_wlord", 32'(bus.wlord), ((k % 2 == 1) ? 32'h1 : 32'h0) | 32'h4);
            check_val("unb_busy", 32'(bus.busy), 32'h1);
            tick();
        end
        check_val("unb_ready", 32'(bus.ins_ready), 32'h1);
        send(2'b01, 0, 4, 4);
        check_val("run_cfg_err", 32'(bus.err), 32'h1);
        check_val("run_cfg_wlord", 32'(bus.wlord), 32'h4);
        check_val("run_cfg_busy", 32'(bus.busy), 32'h1);
        tick();
        check_val("run_cfg_err_pulse", 32'(bus.err), 32'h0);
        check_val("run_cfg_wlord2", 32'(bus.wlord), 32'h5);
        send(2'b11, 0, 0, 0);
        check_val("stop_wlord", 32'(bus.wlord), 32'h0);
        check_val("stop_busy", 32'(bus.busy), 32'h0);
        check_val("stop_done", 32'(bus.done), 32'h1);
        tick();
        check_val("stop_done_pulse", 32'(bus.done), 32'h0);

        // Illegal channel in IDLE, top legal channel, idle no-ops
        send(2'b01, 25, 7, 7);
        check_val("bad_ch_err", 32'(bus.err), 32'h1);
        tick();
        check_val("bad_ch_err_pulse", 32'(bus.err), 32'h0);
        send(2'b01, 19, 2, 0);
        check_val("ch19_err", 32'(bus.err), 32'h0);
        send(2'b11, 0, 0, 0);
        check_val("idle_stop_done", 32'(bus.done), 32'h0);
        check_val("idle_stop_err", 32'(bus.err), 32'h0);
        send(2'b00, 0, 0, 0);
        check_val("idle_nop_err", 32'(bus.err), 32'h0);
        check_val("idle_nop_busy", 32'(bus.busy), 32'h0);

        // Minimum bounded run, N=1
        send(2'b10, 0, 1, 0);
        check_val("n1_busy", 32'(bus.busy), 32'h1);
        check_val("n1_wlord", 32'(bus.wlord), 32'h80005);
        tick();
        check_val("n1_end_busy", 32'(bus.busy), 32'h0);
        check_val("n1_end_done", 32'(bus.done), 32'h1);
        check_val("n1_end_wlord", 32'(bus.wlord), 32'h0);

        // Reset mid-run clears config and state without a done pulse
        send(2'b10, 0, 20, 0);
        for (int k = 0; k < 4; k++) tick();
        rst_n = 1'b0;
        tick();
        check_val("mrst_wlord", 32'(bus.wlord), 32'h0);
        check_val("mrst_busy", 32'(bus.busy), 32'h0);
        check_val("mrst_done", 32'(bus.done), 32'h0);
        rst_n = 1'b1;
        send(2'b10, 0, 5, 0);
        for (int k = 0; k < 5; k++) begin
            check_val("mrst_run_wlord", 32'(bus.wlord), 32'h0);
            check_val("mrst_run_busy", 32'(bus.busy), 32'h1);
            tick();
        end
        check_val("mrst_run_done", 32'(bus.done), 32'h1);

`ifdef WLORD_GEN_CYCCNT_EN
        send(2'b10, 0, 7, 0);
        check_val("cyc_cleared", run_cycles, 32'h0);
        for (int k = 0; k < 7; k++) tick();
        check_val("cyc_done", 32'(bus.done), 32'h1);
        check_val("cyc_count", run_cycles, 32'd7);
        tick();
        check_val("cyc_hold", run_cycles, 32'd7);
        send(2'b10, 0, 3, 0);
        check_val("cyc_restart", run_cycles, 32'h0);
        tick();
        check_val("cyc_inc", run_cycles, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
